// File: rtl/stack_defs.sv
// rtl/stack_defs.sv - opcode and state encodings shared by the stack controller
package stack_defs;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_TOP  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_WRITE   = 2'b01,
    ST_WAIT_RD = 2'b10
  } state_e;

endpackage

// File: rtl/lat_counter.sv
// rtl/lat_counter.sv - loadable down-counter timing out the memory read delay
module lat_counter #(
  parameter int LAT_CYCLES = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam int W = $clog2(LAT_CYCLES + 1);
  localparam logic [W-1:0] LOAD_VAL = W'(LAT_CYCLES);
  localparam logic [W-1:0] ONE      = W'(1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = LOAD_VAL;
    else if (dec_i && cnt_q != '0)
      cnt_d = cnt_q - ONE;
  end

  // Flag looks at the next value so the caller acts on the very edge the count hits zero.
  assign zero_o = (cnt_d == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - LIFO stack controller driving a dual-port memory
module stack_ctrl
  import stack_defs::*;
#(
  parameter int N          = 1024,
  parameter int M          = 32,
  parameter int IND_SIZE   = $clog2(N),
  parameter int LAT_CYCLES = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                op_valid,
  input  logic [1:0]          op_code,
  input  logic [M-1:0]        op_data,
  output logic                op_ready,
  output logic                res_valid,
  output logic [M-1:0]        res_data,
  output logic                res_err,
  output logic [IND_SIZE:0]   count,
  output logic                full,
  output logic                empty,
  output logic [IND_SIZE-1:0] mem_ind1,
  output logic [IND_SIZE-1:0] mem_ind2,
  output logic [M-1:0]        mem_in,
  output logic                mem_beta,
  input  logic [M-1:0]        mem_out2
);

  localparam logic [IND_SIZE:0]   CNT_N   = (IND_SIZE+1)'(N);
  localparam logic [IND_SIZE:0]   CNT_ONE = (IND_SIZE+1)'(1);
  localparam logic [IND_SIZE-1:0] IND_ONE = IND_SIZE'(1);

  state_e              state_q, state_d;
  logic [IND_SIZE:0]   sp_q, sp_d;
  logic [IND_SIZE-1:0] ind1_q, ind1_d;
  logic [M-1:0]        win_q, win_d;
  logic                beta_q, beta_d;
  logic                rv_q, rv_d;
  logic                rerr_q, rerr_d;
  logic [M-1:0]        rdata_q, rdata_d;
  logic                pop_q, pop_d;

  logic accept, is_push, is_rd, push_ok, rd_ok, op_err, lat_zero;
  logic [IND_SIZE-1:0] top_ind;

  assign op_ready = (state_q == ST_IDLE);
  assign full     = (sp_q == CNT_N);
  assign empty    = (sp_q == '0);
  assign count    = sp_q;
  assign accept   = op_valid && op_ready;
  assign is_push  = (op_code == OP_PUSH);
  assign is_rd    = (op_code == OP_POP) || (op_code == OP_TOP);
  assign push_ok  = accept && is_push && !full;
  assign rd_ok    = accept && is_rd && !empty;
  assign op_err   = accept && ((is_push && full) || (is_rd && empty));

  // Low bits wrap correctly even when sp == N.
  assign top_ind  = sp_q[IND_SIZE-1:0] - IND_ONE;
  assign mem_ind2 = empty ? '0 : top_ind;

  assign mem_ind1  = ind1_q;
  assign mem_in    = win_q;
  assign mem_beta  = beta_q;
  assign res_valid = rv_q;
  assign res_err   = rerr_q;
  assign res_data  = rdata_q;

  lat_counter #(.LAT_CYCLES(LAT_CYCLES)) u_lat (
    .clk_i  (clock),
    .rst_i  (reset),
    .load_i (rd_ok),
    .dec_i  (state_q == ST_WAIT_RD),
    .zero_o (lat_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sp_q    <= '0;
      ind1_q  <= '0;
      win_q   <= '0;
      beta_q  <= 1'b0;
      rv_q    <= 1'b0;
      rerr_q  <= 1'b0;
      rdata_q <= '0;
      pop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      ind1_q  <= ind1_d;
      win_q   <= win_d;
      beta_q  <= beta_d;
      rv_q    <= rv_d;
      rerr_q  <= rerr_d;
      rdata_q <= rdata_d;
      pop_q   <= pop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (push_ok)    state_d = ST_WRITE;
        else if (rd_ok) state_d = ST_WAIT_RD;
      end
      ST_WRITE:   state_d = ST_IDLE;
      ST_WAIT_RD: if (lat_zero) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sp_d    = sp_q;
    ind1_d  = ind1_q;
    win_d   = win_q;
    beta_d  = 1'b0;
    rv_d    = 1'b0;
    rerr_d  = 1'b0;
    rdata_d = rdata_q;
    pop_d   = pop_q;
    case (state_q)
      ST_IDLE: begin
        if (push_ok) begin
          ind1_d = sp_q[IND_SIZE-1:0];
          win_d  = op_data;
          beta_d = 1'b1;
        end
        if (rd_ok) pop_d = (op_code == OP_POP);
        if (op_err) begin
          rv_d    = 1'b1;
          rerr_d  = 1'b1;
          rdata_d = '0;
        end
      end
      ST_WRITE: begin
        sp_d    = sp_q + CNT_ONE;
        rv_d    = 1'b1;
        rdata_d = win_q;
      end
      ST_WAIT_RD: begin
        if (lat_zero) begin
          rv_d    = 1'b1;
          rdata_d = mem_out2;
          if (pop_q) sp_d = sp_q - CNT_ONE;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Controller that turns the dual-port memory (1 R/W port, 1 read port, negedge write on beta) into a LIFO stack unit.
- Accepts PUSH/POP/TOP requests over a valid/ready handshake and keeps the stack pointer.
- Drives the memory address, data and beta lines, and waits out the memory access delay before sampling read data.
- Returns one result per accepted operation, with an error flag on overflow or underflow.

Parameters:
- N, 1024, stack depth (memory positions).
- M, 32, word width in bits.
- IND_SIZE, $clog2(N), memory address width.
- LAT_CYCLES, 1, clock cycles to wait for memory read data to settle; minimum 1; must satisfy LAT_CYCLES*Tclk >= memory access delay.

Ports:
- clock  in  1  system clock; state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- op_valid  in  1  request present.
- op_code  in  2  00 NOP, 01 PUSH, 10 POP, 11 TOP.
- op_data  in  M  PUSH operand.
- op_ready  out  1  controller can accept a request.
- res_valid  out  1  one-cycle result strobe.
- res_data  out  M  PUSH: pushed word; POP/TOP: top word; error: 0.
- res_err  out  1  qualified by res_valid; overflow or underflow.
- count  out  IND_SIZE+1  current number of stacked words.
- full  out  1  count == N.
- empty  out  1  count == 0.
- mem_ind1  out  IND_SIZE  R/W port address (write address).
- mem_ind2  out  IND_SIZE  read port address.
- mem_in  out  M  write data.
- mem_beta  out  1  write enable; the memory writes on the negedge while it is high.
- mem_out2  in  M  read port data.

Behaviour:
- Reset values (asynchronous):
  - state IDLE, sp (=count) 0.
  - mem_beta 0, res_valid 0, res_err 0, res_data 0, mem_in 0, mem_ind1 0.
  - op_ready 1, empty 1, full 0.
  - Memory contents are not cleared.
- States: IDLE, WRITE, WAIT_RD. op_ready = (state == IDLE).
- Handshake: a request is accepted at a posedge where op_valid && op_ready. op_code/op_data are sampled only then.
- NOP: accepted, no effect, no res_valid.
- PUSH, not full:
  - At accept edge E0: latch mem_ind1 = sp and mem_in = op_data, set mem_beta = 1, go to WRITE.
  - In WRITE: mem_beta is high for exactly one cycle; the write lands at that cycle's negedge.
  - At E1: mem_beta = 0, sp = sp+1, res_valid = 1, res_data = pushed word, res_err = 0, go to IDLE.
- POP/TOP, not empty:
  - mem_ind2 = sp-1, combinational from sp; it is held stable because sp only changes on completion.
  - At E0: load latency counter with LAT_CYCLES, go to WAIT_RD.
  - The counter decrements each cycle. At edge E_LAT (LAT_CYCLES edges after E0): res_data = mem_out2, res_valid = 1, res_err = 0, go to IDLE.
  - POP only: sp = sp-1 at E_LAT.
- mem_ind2 = 0 when sp == 0.
- PUSH when full, or POP/TOP when empty:
  - No memory access, sp unchanged, state stays IDLE.
  - At E0: res_valid = 1, res_err = 1, res_data = 0.
- res_valid is a single-cycle pulse. There is no result backpressure; consumers must take it.
- A new request may be accepted in the same cycle res_valid is high (back-to-back operation).
- Latency from accept to result-visible cycle:
  - PUSH: 2 cycles (strobe in cycle after E1).
  - POP/TOP: LAT_CYCLES+1.
  - Error: 1.
- Maximum throughput: one PUSH per 2 cycles.
- Reset mid-operation: state returns to IDLE, and mem_beta drops immediately (asynchronously), so no write lands after reset asserts. Any pending result is discarded. Reset released with op_valid high: accepted at the first posedge after release.
- count never exceeds N and never wraps; full and empty are derived from count.

Decomposition:
- Shared package stack_defs holds:
  - opcode constants OP_NOP/OP_PUSH/OP_POP/OP_TOP;
  - state encoding ST_IDLE/ST_WRITE/ST_WAIT_RD.
- One sub-module: lat_counter, a loadable down-counter with a zero flag, parameterised by LAT_CYCLES. It is used for the WAIT_RD timeout.
- The top level connects to MEMORIA with ind1/ind2/in/beta/out2; out1 is left unused.

Test Plan:
- Reset, then PUSH 0xA5, PUSH 0x3C (N=4) -> each res_valid 2 cycles after accept, res_err=0; count=2; memory[0]=0xA5, memory[1]=0x3C.
- TOP, then POP, POP after the pushes above -> res_data 0x3C, 0x3C, 0xA5, each LAT_CYCLES+1 after accept; count 2, 1, 0; empty=1 at end.
- POP on empty -> res_valid,res_err=1, res_data=0, one cycle after accept; count stays 0; mem_beta never high.
- N=4: push 4 words then a fifth PUSH 0xFF -> full=1, fifth returns res_err=1; memory[3] unchanged; count=4.
- Reset asserted during WRITE cycle of PUSH 0x77 (asynchronously, before the negedge) -> mem_beta drops at once, no memory write, count=0, op_ready=1, no res_valid.
- LAT_CYCLES=3, memory delay 25 with Tclk=10: PUSH 0x11, then TOP -> res_data=0x11 exactly 4 cycles after accept, mem_ind2 stable=0 throughout WAIT_RD.
